// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg - shared definitions for the br_sb register bank and its scoreboard.
//   ew_t      : write-mode encodings driven on EW by writeback.
//   DW_DEF    : default data width.
//   NREG_DEF  : default register count.
//   REG_ZERO  : index of the hard-wired zero register.
// ---------------------------------------------------------------------------
package br_pkg;

    typedef enum logic [1:0] {
        EW_NONE = 2'b00,
        EW_FLAG = 2'b01,
        EW_LINK = 2'b10,
        EW_GEN  = 2'b11
    } ew_t;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/br_scoreboard.sv
// ---------------------------------------------------------------------------
// br_scoreboard - busy-bit tracking for outstanding multi-cycle loads.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ra1, ra2        : decode read addresses
//   bsy1, bsy2      : addressed register still waiting on its load
//   iss_v, iss_a    : load issue request and destination
//   iss_rdy         : issue accepted this cycle
//   ret_v, ret_a    : load return and destination
//   ret_ok          : the return matches a pending load (drives the write)
//   wr_v, wr_a      : general/link write from writeback (hazard detection)
//   pend            : number of outstanding loads
//   err             : registered one-cycle protocol-violation pulse
// ---------------------------------------------------------------------------
module br_scoreboard
    import br_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int MAX_PEND = 4,
    localparam int PW      = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          bsy1,
    output logic          bsy2,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_a,
    output logic          iss_rdy,
    input  logic          ret_v,
    input  logic [AW-1:0] ret_a,
    output logic          ret_ok,
    input  logic          wr_v,
    input  logic [AW-1:0] wr_a,
    output logic [PW-1:0] pend,
    output logic          err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic            err_q;
    logic            ret_nz, ret_bad, wr_nz, waw, room;

    // Anything aimed at the zero register is dropped silently.
    assign ret_nz  = ret_v && (ret_a != AW'(REG_ZERO));
    assign ret_ok  = ret_nz && busy_q[ret_a];
    assign ret_bad = ret_nz && !busy_q[ret_a];

    // A write to a busy register covers both the WAW hazard and the
    // write/retire collision, since a valid retire implies busy.
    assign wr_nz = wr_v && (wr_a != AW'(REG_ZERO));
    assign waw   = wr_nz && busy_q[wr_a];

    // A retiring load frees its register and a PEND slot this very cycle.
    assign bsy1 = busy_q[ra1] && !(ret_ok && (ret_a == ra1));
    assign bsy2 = busy_q[ra2] && !(ret_ok && (ret_a == ra2));

    assign room    = (pend_q < PW'(MAX_PEND)) || ret_ok;
    assign iss_rdy = iss_v && (iss_a != AW'(REG_ZERO)) && room &&
                     (!busy_q[iss_a] || (ret_ok && (ret_a == iss_a)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (ret_ok)  busy_d[ret_a] = 1'b0;
        // Set after clear: a re-issue to the retiring register stays busy.
        if (iss_rdy) busy_d[iss_a] = 1'b1;

        pend_d = pend_q;
        if (iss_rdy && !ret_ok)      pend_d = pend_q + PW'(1);
        else if (ret_ok && !iss_rdy) pend_d = pend_q - PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // flops sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= ret_bad || waw;
        end
    end

    assign pend = pend_q;
    assign err  = err_q;

endmodule

// File: rtl/br_sb.sv
// ---------------------------------------------------------------------------
// br_sb - parametrised register bank with write-through bypass, a flag
// register and a load scoreboard that generates decode stalls.
//   clk, rst_n          : clock, asynchronous active-low reset
//   RA1/RA2, DR1/DR2    : read addresses, bypassed combinational read data
//   BSY1/BSY2, STALL    : pending-load status of the read operands
//   EW, WA, WD, DJ      : writeback mode, general address/data, link data
//   FSEL, DF            : flag bit select and value
//   FLAGS, CFL          : flag register and its bit 0
//   ISS_V/ISS_A/ISS_RDY : load issue handshake
//   RET_V/RET_A/RET_D   : load return path
//   PEND, ERR           : outstanding-load count, violation pulse
// ---------------------------------------------------------------------------
module br_sb
    import br_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int AW        = $clog2(NREG),
    parameter int NFLAG     = 4,
    parameter int MAX_PEND  = 4,
    parameter int LINK_ADDR = NREG - 1,
    localparam int FW       = (NFLAG > 1) ? $clog2(NFLAG) : 1,
    localparam int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [DW-1:0]    DR1,
    output logic [DW-1:0]    DR2,
    output logic             BSY1,
    output logic             BSY2,
    output logic             STALL,
    input  logic [1:0]       EW,
    input  logic [AW-1:0]    WA,
    input  logic [DW-1:0]    WD,
    input  logic [DW-1:0]    DJ,
    input  logic [FW-1:0]    FSEL,
    input  logic             DF,
    output logic [NFLAG-1:0] FLAGS,
    output logic             CFL,
    input  logic             ISS_V,
    input  logic [AW-1:0]    ISS_A,
    output logic             ISS_RDY,
    input  logic             RET_V,
    input  logic [AW-1:0]    RET_A,
    input  logic [DW-1:0]    RET_D,
    output logic [PW-1:0]    PEND,
    output logic             ERR
);

    localparam logic [AW-1:0] LINK_A = AW'(LINK_ADDR);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DW-1:0]    reg_q [NREG];
    logic [NFLAG-1:0] flags_q;

    ew_t           ew;
    logic          wr_gen, wr_link, wr_v, ret_ok;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    logic [AW-1:0] ra [2];
    logic [DW-1:0] dr [2];

    assign ew      = ew_t'(EW);
    assign wr_gen  = (ew == EW_GEN);
    assign wr_link = (ew == EW_LINK);
    assign wr_v    = wr_gen || wr_link;
    assign wr_a    = wr_gen ? WA : LINK_A;
    assign wr_d    = wr_gen ? WD : DJ;

    br_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1     (RA1),
        .ra2     (RA2),
        .bsy1    (BSY1),
        .bsy2    (BSY2),
        .iss_v   (ISS_V),
        .iss_a   (ISS_A),
        .iss_rdy (ISS_RDY),
        .ret_v   (RET_V),
        .ret_a   (RET_A),
        .ret_ok  (ret_ok),
        .wr_v    (wr_v),
        .wr_a    (wr_a),
        .pend    (PEND),
        .err     (ERR)
    );

    // Storage. The zero register is never written, so it holds its reset 0.
    // NOTE: the register array is reset because a cleared bank is
    // architecturally visible straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
            flags_q <= '0;
        end else begin
            if (ret_ok) reg_q[RET_A] <= RET_D;
            // Later assignment wins: writeback beats a colliding retire.
            if (wr_v && (wr_a != ZERO_A)) reg_q[wr_a] <= wr_d;
            if (ew == EW_FLAG) flags_q[FSEL] <= DF;
        end
    end

    // Bypass muxes, lowest priority first so later ifs override.
    assign ra[0] = RA1;
    assign ra[1] = RA2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dr[p] = reg_q[ra[p]];
            if (ret_ok && (RET_A == ra[p]))   dr[p] = RET_D;
            if (wr_link && (ra[p] == LINK_A)) dr[p] = DJ;
            if (wr_gen && (WA == ra[p]))      dr[p] = WD;
            if (ra[p] == ZERO_A)              dr[p] = '0;
        end
    end

    assign DR1   = dr[0];
    assign DR2   = dr[1];
    assign STALL = BSY1 | BSY2;
    assign FLAGS = flags_q;
    assign CFL   = flags_q[0];

endmodule

// File: tb/tb_br_sb.sv
// ---------------------------------------------------------------------------
// tb_br_sb - self-checking bench for br_sb: directed scenarios followed by
// random traffic compared against a behavioural model of the register bank.
// ---------------------------------------------------------------------------
module tb_br_sb;
    import br_pkg::*;

    localparam int DW       = 32;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int NFLAG    = 4;
    localparam int FW       = 2;
    localparam int MAX_PEND = 4;
    localparam int PW       = 3;
    localparam int LINK     = NREG - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    ra1, ra2, wa, iss_a, ret_a;
    logic [DW-1:0]    dr1, dr2, wd, dj, ret_d;
    logic             bsy1, bsy2, stall, df, cfl, iss_v, iss_rdy, ret_v, err;
    logic [1:0]       ew;
    logic [FW-1:0]    fsel;
    logic [NFLAG-1:0] flags;
    logic [PW-1:0]    pend;

    always #5 clk = ~clk;

    br_sb #(
        .DW(DW), .NREG(NREG), .AW(AW), .NFLAG(NFLAG),
        .MAX_PEND(MAX_PEND), .LINK_ADDR(LINK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1(ra1), .RA2(ra2), .DR1(dr1), .DR2(dr2),
        .BSY1(bsy1), .BSY2(bsy2), .STALL(stall),
        .EW(ew), .WA(wa), .WD(wd), .DJ(dj), .FSEL(fsel), .DF(df),
        .FLAGS(flags), .CFL(cfl),
        .ISS_V(iss_v), .ISS_A(iss_a), .ISS_RDY(iss_rdy),
        .RET_V(ret_v), .RET_A(ret_a), .RET_D(ret_d),
        .PEND(pend), .ERR(err)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0]    m_reg  [NREG];
    bit               m_busy [NREG];
    logic [NFLAG-1:0] m_flags;
    bit               m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit ret_valid();
        return ret_v && ret_a != 0 && m_busy[ret_a];
    endfunction

    function automatic logic [DW-1:0] exp_dr(input logic [AW-1:0] a);
        if (a == 0)                                  return '0;
        if (ew == 2'b11 && wa == a)                  return wd;
        if (ew == 2'b10 && a == AW'(LINK))           return dj;
        if (ret_valid() && ret_a == a)               return ret_d;
        return m_reg[a];
    endfunction

    function automatic bit exp_bsy(input logic [AW-1:0] a);
        return m_busy[a] && !(ret_valid() && ret_a == a);
    endfunction

    function automatic bit exp_rdy();
        bit free_reg = !m_busy[iss_a] || (ret_valid() && ret_a == iss_a);
        bit slot     = pending() < MAX_PEND || ret_valid();
        return iss_v && iss_a != 0 && free_reg && slot;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_flags = '0;
        m_err   = 1'b0;
    endtask

    // Applies the inputs present just before a rising edge.
    task automatic model_clock();
        bit            rv  = ret_valid();
        bit            acc = exp_rdy();
        bit            wv  = (ew == 2'b11) || (ew == 2'b10);
        logic [AW-1:0] a   = (ew == 2'b11) ? wa : AW'(LINK);
        m_err = (ret_v && ret_a != 0 && !m_busy[ret_a]) || (wv && a != 0 && m_busy[a]);
        if (rv) begin
            m_reg[ret_a]  = ret_d;
            m_busy[ret_a] = 1'b0;
        end
        if (wv && a != 0) m_reg[a] = (ew == 2'b11) ? wd : dj;
        if (ew == 2'b01) m_flags[fsel] = df;
        if (acc) m_busy[iss_a] = 1'b1;
    endtask

    task automatic check_outputs();
        check("dr1",     dr1,     exp_dr(ra1));
        check("dr2",     dr2,     exp_dr(ra2));
        check("bsy1",    bsy1,    exp_bsy(ra1));
        check("bsy2",    bsy2,    exp_bsy(ra2));
        check("stall",   stall,   exp_bsy(ra1) | exp_bsy(ra2));
        check("iss_rdy", iss_rdy, exp_rdy());
        check("flags",   flags,   m_flags);
        check("cfl",     cfl,     m_flags[0]);
        check("pend",    pend,    pending());
        check("err",     err,     m_err);
    endtask

    // Called right after a falling edge with inputs already driven.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        ew = 2'b00; iss_v = 1'b0; ret_v = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    function automatic logic [AW-1:0] pick_busy();
        int s = $urandom_range(0, NREG - 1);
        for (int i = 0; i < NREG; i++)
            if (m_busy[(s + i) % NREG]) return AW'((s + i) % NREG);
        return rnd_addr();
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; dj = '0; fsel = '0; df = 1'b0;
        iss_a = 5'd1; ret_a = '0; ret_d = '0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. reset mid-operation
        ew = 2'b11; wa = 5'd5; wd = 32'hA5; step();
        idle(); iss_v = 1'b1; iss_a = 5'd7; step();
        idle(); ra1 = 5'd5; ra2 = 5'd7;
        #1 check("pre_rst_dr1", dr1, 32'hA5);
        check("pre_rst_bsy2", bsy2, 1'b1);
        rst_n = 1'b0;
        #1 check("rst_dr1", dr1, 32'h0);
        check("rst_bsy2", bsy2, 1'b0);
        check("rst_pend", pend, 3'd0);
        check("rst_flags", flags, 4'h0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 2. bypass and register 0
        ew = 2'b11; wa = 5'd9; wd = 32'h1234; ra1 = 5'd9;
        #1 check("bypass_same", dr1, 32'h1234);
        step();
        idle();
        #1 check("bypass_next", dr1, 32'h1234);
        step();
        ew = 2'b11; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; step();
        idle();
        #1 check("reg0", dr1, 32'h0);
        step();

        // 3. link and flag writes
        ew = 2'b10; dj = 32'h40; step();
        idle(); ra1 = 5'd31;
        #1 check("link", dr1, 32'h40);
        ew = 2'b01; fsel = 2'd2; df = 1'b1; step();
        idle();
        #1 check("flag2", flags, 4'b0100);
        check("cfl0", cfl, 1'b0);
        ew = 2'b01; fsel = 2'd0; df = 1'b1; step();
        idle();
        #1 check("cfl1", cfl, 1'b1);
        step();

        // 4. scoreboard fill and recovery
        for (int r = 1; r <= 4; r++) begin
            iss_v = 1'b1; iss_a = AW'(r); step();
        end
        idle();
        #1 check("fill_pend", pend, 3'd4);
        iss_v = 1'b1; iss_a = 5'd5;
        #1 check("full_rdy", iss_rdy, 1'b0);
        step();
        iss_v = 1'b1; iss_a = 5'd5; ret_v = 1'b1; ret_a = 5'd2; ret_d = 32'h77;
        #1 check("swap_rdy", iss_rdy, 1'b1);
        step();
        idle(); ra1 = 5'd2; ra2 = 5'd5;
        #1 check("swap_pend", pend, 3'd4);
        check("swap_r2", dr1, 32'h77);
        check("swap_bsy5", bsy2, 1'b1);
        step();

        // 5. stall released by a same-cycle retire
        ra1 = 5'd3; ra2 = 5'd0;
        #1 check("stall_on", stall, 1'b1);
        ret_v = 1'b1; ret_a = 5'd3; ret_d = 32'hBEEF;
        #1 check("ret_bsy1", bsy1, 1'b0);
        check("ret_stall", stall, 1'b0);
        check("ret_dr1", dr1, 32'hBEEF);
        step();

        // 6. violations
        idle(); ra1 = 5'd6; ret_v = 1'b1; ret_a = 5'd6; ret_d = 32'hDEAD; step();
        idle();
        #1 check("bad_ret_err", err, 1'b1);
        check("bad_ret_pend", pend, 3'd3);
        check("bad_ret_r6", dr1, 32'h0);
        step();
        #1 check("err_clear", err, 1'b0);
        ew = 2'b11; wa = 5'd4; wd = 32'hCAFE; step();
        idle(); ra1 = 5'd4;
        #1 check("waw_err", err, 1'b1);
        check("waw_data", dr1, 32'hCAFE);
        check("waw_busy", bsy1, 1'b1);
        step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            ra1   = rnd_addr();
            ra2   = ($urandom_range(0, 3) == 0) ? ra1 : rnd_addr();
            ew    = 2'($urandom_range(0, 3));
            wa    = ($urandom_range(0, 2) == 0) ? ra1 : rnd_addr();
            wd    = $urandom;
            dj    = $urandom;
            fsel  = FW'($urandom_range(0, NFLAG - 1));
            df    = 1'($urandom_range(0, 1));
            iss_v = ($urandom_range(0, 2) != 0);
            iss_a = AW'($urandom_range(1, 7));
            ret_v = ($urandom_range(0, 1) == 0);
            ret_a = ($urandom_range(0, 3) != 0) ? pick_busy() : rnd_addr();
            if ($urandom_range(0, 7) == 0) iss_a = ret_a;
            if (iss_a == 0) iss_a = 5'd1;
            ret_d = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/br_sb.md
Name: br_sb

Overview:
Parametrised register bank with a load scoreboard: next generation of the core's 32x32 register bank.
- Generalises data width, register count and flag-register width.
- Adds asynchronous reset, write-through read bypass and a second write path for returning multi-cycle loads.
- Adds a busy-bit scoreboard that drives decode-stage stalls.
- Sits between decode (read ports, issue), writeback (general/link/flag writes) and the memory return path (retire).

Parameters:
DW, 32, data width of each register.
NREG, 32, number of registers (power of two, >=4).
AW, $clog2(NREG), register address width.
NFLAG, 4, width of the flag register RF.
MAX_PEND, 4, maximum outstanding pending loads (1..NREG-1).
LINK_ADDR, NREG-1, register written by jump-link writes.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
RA1, RA2  in  AW  read addresses.
DR1, DR2  out  DW  read data (combinational, bypassed).
BSY1, BSY2  out  1  addressed register has a pending load.
STALL  out  1  BSY1 | BSY2.
EW  in  2  write mode: 00 none, 01 flag, 10 link, 11 general.
WA  in  AW  general write address.
WD  in  DW  general write data.
DJ  in  DW  link write data.
FSEL  in  $clog2(NFLAG)  flag bit select.
DF  in  1  flag bit data.
FLAGS  out  NFLAG  flag register contents.
CFL  out  1  FLAGS[0].
ISS_V  in  1  issue load targeting ISS_A.
ISS_A  in  AW  load destination.
ISS_RDY  out  1  issue accepted this cycle.
RET_V  in  1  load data returning.
RET_A  in  AW  returning destination.
RET_D  in  DW  returning data.
PEND  out  $clog2(MAX_PEND+1)  outstanding-load count.
ERR  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers, FLAGS, busy bits, PEND and ERR = 0.
  - Outputs follow the cleared state immediately.
- Register 0:
  - reads 0 always.
  - writes, issues and retires targeting it are ignored; no ERR.
- Write decode on the rising edge:
  - EW=01: FLAGS[FSEL] <= DF.
  - EW=10: reg[LINK_ADDR] <= DJ.
  - EW=11: reg[WA] <= WD.
  - EW=00: no write.
- Retire: RET_V with busy[RET_A]=1 writes reg[RET_A] <= RET_D, clears busy[RET_A] and decrements PEND.
- Read bypass (DR1 shown; DR2 identical on RA2):
  - general write with WA==RA1 -> DR1=WD.
  - else link write with RA1==LINK_ADDR -> DR1=DJ.
  - else valid retire with RET_A==RA1 -> DR1=RET_D.
  - else stored value.
- Busy/stall outputs:
  - BSY1 = busy[RA1] & ~(valid retire to RA1 this cycle); BSY2 likewise on RA2.
  - Issue in the same cycle does not affect BSY.
- Issue acceptance:
  - ISS_RDY = ISS_V & ~busy[ISS_A] & (PEND<MAX_PEND | retire this cycle).
  - Accepted issue sets busy[ISS_A] and increments PEND.
  - Accepted issue plus retire in the same cycle leaves PEND unchanged.
  - An issue with ISS_A==RET_A is accepted: busy stays 1.
- Collisions:
  - General/link write and retire to the same address: the general/link write wins, the retire still clears busy and decrements PEND, and ERR pulses.
  - General or link write to a busy register: write performed, busy unchanged, ERR pulses (WAW hazard).
- Invalid retire: RET_V to a non-busy register (nonzero address) -> no write, PEND unchanged, ERR pulses.
- PEND saturation: PEND never exceeds MAX_PEND and never underflows.
- ERR is registered: it pulses high for exactly the cycle after the violation.

Decomposition:
- Shared package br_pkg holds:
  - EW encodings: EW_NONE, EW_FLAG, EW_LINK, EW_GEN.
  - DW/NREG defaults.
  - The reg-0 constant.
- One natural sub-module, br_scoreboard: busy bits, PEND counter, ISS_RDY/BSY logic and ERR detection for retires.
- Storage array and bypass muxes stay in br_sb.

Test Plan:
1. Reset mid-operation:
   - Setup: write reg[5]=0xA5, issue load to r7.
   - Stimulus: assert rst_n=0 between clock edges.
   - Response: DR(5)=0, BSY(7)=0, PEND=0, FLAGS=0 immediately, with no clock edge.
2. Bypass:
   - Stimulus: EW=11, WA=RA1=9, WD=0x1234 in one cycle.
   - Response: DR1=0x1234 in that same cycle; the next cycle with no write also gives DR1=0x1234.
   - Also: write to reg 0 leaves DR=0.
3. Link and flag writes:
   - Stimulus: EW=10, DJ=0x40.
   - Response: reg[31]=0x40.
   - Stimulus: EW=01, FSEL=2, DF=1.
   - Response: FLAGS=4'b0100, CFL=0.
   - Stimulus: then FSEL=0, DF=1.
   - Response: CFL=1.
4. Scoreboard fill and recovery:
   - Stimulus: issue to r1..r4 on consecutive cycles.
   - Response: PEND=4.
   - Stimulus: issue r5.
   - Response: ISS_RDY=0.
   - Stimulus: issue r5 while retiring r2 (0x77) in the same cycle.
   - Response: accepted, PEND stays 4, reg[2]=0x77, BSY on r5=1.
5. Stall:
   - Stimulus: RA1=3 with r3 pending.
   - Response: STALL=1.
   - Stimulus: retire r3 (0xBEEF) in that cycle.
   - Response: BSY1=0, STALL=0, DR1=0xBEEF in that same cycle.
6. Violations:
   - Stimulus: retire to non-busy r6.
   - Response: reg[6] unchanged, ERR pulses 1 cycle later, PEND unchanged.
   - Stimulus: general write to busy r4.
   - Response: written, busy kept, ERR pulses.
